activehigh_serial_encoder: RTL and testbench
============================================

// Module: activehigh_serial_encoder
// PURPOSE
//  - Reverse direction of the 2-to-4 active-high decoder: accepts a 2**CODE_W-bit active-high line vector, returns binary codes s.
//  - Multi-hot vectors are serialized: one code per active line, lowest index first; LAST marks the final code of a vector.
//  - Sits between line-level request sources and code-driven logic; output codes feed the decoder select inputs directly.
// PARAMETERS
//  - CODE_W   2   code width; line vector width N = 2**CODE_W (default N=4)
// PORTS
//  - clk        in   1       rising-edge clock
//  - rst_n      in   1       asynchronous active-low reset
//  - d          in   N       active-high line vector; d[i]=1 => line i active
//  - in_valid   in   1       d is valid this cycle
//  - in_ready   out  1       block accepts d this cycle
//  - s          out  CODE_W  binary code of current line (s[CODE_W-1] = MSB, i.e. {s1,s0})
//  - out_valid  out  1       s/last valid this cycle
//  - out_ready  in   1       consumer takes s this cycle
//  - last       out  1       current code is the final one from the accepted vector
// BEHAVIOUR
//  - One clock; async active-low reset; all state in registers clocked on posedge clk.
//  - Reset (async assert, sync-safe deassert by source): state=IDLE, pend=0, s=0, out_valid=0, last=0; in_ready=1 from the first edge after release.
//  - in_ready is combinational from state: 1 in IDLE, 0 in BUSY. Input accepted when in_valid && in_ready.
//  - out_valid, s, last are registered/derived from pend only; no combinational path from d or in_valid to outputs.
//  - FSM IDLE:
//     accept && d!=0 -> pend<=d, go BUSY.
//     accept && d==0 -> vector consumed and dropped; stay IDLE; no output.
//     no accept -> stay IDLE.
//  - FSM BUSY: out_valid=1; s = index of lowest set bit of pend; last = (pend has exactly one bit set).
//     out_ready=1 -> clear that bit in pend; if last, go IDLE (out_valid=0 next cycle), else stay BUSY with next-lowest bit.
//     out_ready=0 -> s, last, pend held stable (AXI-style: valid never drops without handshake).
//  - Latency: vector accepted at edge k -> first code valid after edge k; K active lines need K handshake cycles minimum.
//  - Throughput: no overlap between vectors; in_ready returns 1 the cycle after the last handshake (one bubble per vector).
//  - Changes to d while in BUSY are ignored (in_ready=0); input is not sampled.
//  - Reset mid-operation: pend discarded immediately, out_valid drops asynchronously, no partial codes after release.
//  - Index arithmetic: s width CODE_W, covers 0..N-1 exactly; no wrap; all-ones vector yields codes 0,1,..,N-1 with last on N-1.
// CONFIGURATION
//  - Macro ENC_ONEHOT_ERR_EN:
//     defined: adds ports err (out,1) and err_clr (in,1); err sets (sticky, registered) on accepting any vector with >1 bit set;
//       cleared by err_clr=1 at a clock edge; set wins over clear in the same cycle; reset value 0; serialization unchanged.
//     undefined: no err/err_clr ports; multi-hot vectors serialized silently.
// TESTING
//  - Reset: rst_n=0 mid-BUSY with pend=4'b1010 -> out_valid=0 at once; after release in_ready=1, out_valid=0, s=0.
//  - One-hot: d=4'b0100 accepted, out_ready=1 -> next cycle s=2'b10, last=1; following cycle out_valid=0, in_ready=1.
//  - Multi-hot: d=4'b1011, out_ready=1 -> codes 0,1,3 on consecutive cycles; last=1 only with s=3.
//  - Backpressure: d=4'b0110, out_ready=0 for 5 cycles -> s=1, last=0 held stable; then out_ready=1 -> s=2, last=1.
//  - Zero/ignored input: d=4'b0000 accepted -> no out_valid; while BUSY on 4'b0001, d=4'b1000 with in_valid=1 -> ignored, only code 0 emitted.
//  - ENC_ONEHOT_ERR_EN: d=4'b0011 -> err=1 after accept, stays 1; err_clr=1 -> err=0; d=4'b1000 -> err stays 0.

Source files
------------

// File: rtl/activehigh_serial_encoder.sv
// activehigh_serial_encoder
//   Converts a 2**CODE_W-bit active-high line vector into binary line codes.
//   If several lines are active, the block emits one code per active line, lowest
//   index first, and asserts `last` with the final code.
//   Input side: valid/ready. Output side: valid/ready, AXI-style: s and last
//   stay stable while out_valid=1 and out_ready=0.
//   Vectors do not overlap. in_ready is 1 only in IDLE.
//   Optional feature macro: ENC_ONEHOT_ERR_EN. When defined, it adds a sticky
//   `err` flag that sets when an accepted vector has more than one bit set, and an
//   `err_clr` input that clears it.

module activehigh_serial_encoder #(
    parameter int CODE_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2**CODE_W-1:0] d,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CODE_W-1:0]    s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 last
`ifdef ENC_ONEHOT_ERR_EN
    ,
    output logic                 err,
    input  logic                 err_clr
`endif
);

    localparam int N = 2**CODE_W;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]   state;
    logic [N-1:0] pend;        // lines still waiting to be emitted
    logic [N-1:0] pend_next;   // pend with its lowest set bit removed
    logic         accept;
    logic         handshake;

    // Input handshake depends only on state, so d/in_valid never reach an output.
    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == BUSY);
    assign handshake = out_valid && out_ready;

    // x & (x-1) removes the lowest set bit. If nothing remains, this code is the last one.
    assign pend_next = pend & (pend - ONE);
    assign last      = (pend != '0) && (pend_next == '0);

    // Priority encode the lowest set bit of pend. s reads 0 when pend is empty.
    always_comb begin
        // NOTE: s gets a default before the loop, so every path assigns it and no latch is inferred.
        s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend[i]) begin
                s = CODE_W'(i);
            end
        end
    end

    // Controller: load pend on a non-zero accept; pop one line per output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: reset is asynchronous, so pending codes are discarded and out_valid falls without waiting for a clock.
            state <= IDLE;
            pend  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments, so all registers update together from pre-edge values.
            case (state)
                IDLE: begin
                    // An all-zero vector is consumed, and the block stays in IDLE.
                    if (accept && (d != '0)) begin
                        pend  <= d;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (handshake) begin
                        pend <= pend_next;
                        if (last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pend  <= '0;
                end
            endcase
        end
    end

`ifdef ENC_ONEHOT_ERR_EN
    logic multi_hot;

    // A vector with more than one bit set still has bits left after its lowest bit is removed.
    assign multi_hot = (d & (d - ONE)) != '0;

    // Sticky error flag. Set has priority over clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept && multi_hot) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_activehigh_serial_encoder.sv
// Testbench for activehigh_serial_encoder (CODE_W=2, N=4).
// Reference model: for a vector v, the expected output is the list of indices of
// the set bits, in ascending order; the last entry carries last=1.
// Define ENC_ONEHOT_ERR_EN to build and exercise the sticky error flag as well.

module tb_activehigh_serial_encoder;

    localparam int CODE_W = 2;
    localparam int N      = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      d;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] s;
    logic              out_valid;
    logic              out_ready;
    logic              last;
`ifdef ENC_ONEHOT_ERR_EN
    logic              err;
    logic              err_clr;
`endif

    int checks = 0;
    int errors = 0;

    activehigh_serial_encoder #(.CODE_W(CODE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last)
`ifdef ENC_ONEHOT_ERR_EN
        ,
        .err       (err),
        .err_clr   (err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the edge before anything is sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: indices of the active lines, lowest index first.
    function automatic void codes_of(input logic [N-1:0] v, output int q[$]);
        q = {};
        for (int i = 0; i < N; i++) begin
            if (v[i] === 1'b1) q.push_back(i);
        end
    endfunction

    // Offer v with in_valid for one accepting edge.
    // ok=0 means in_ready did not appear within 20 cycles.
    task automatic offer(input logic [N-1:0] v, output bit ok);
        int waited = 0;
        ok = 1'b1;
        while (in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            ok = 1'b0;
        end else begin
            d        = v;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            d        = $urandom_range(0, N * N - 1) % (N * N);
        end
    endtask

    task automatic test_reset();
        bit ok;
        out_ready = 1'b0;
        offer(4'b1010, ok);
        checks++;
        if (!ok || out_valid !== 1'b1 || s !== 2'd1) begin
            errors++;
            $display("FAIL reset_preload: ok=%0d out_valid=%b s=%0d, required ok=1 out_valid=1 s=1", ok, out_valid, s);
        end
        // Assert reset between clock edges. out_valid must fall without waiting for an edge.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b, required 0", out_valid);
        end
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 2'd0 || last !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b s=%0d last=%b, required 1 0 0 0", in_ready, out_valid, s, last);
        end
        // No partial codes may reappear after reset is released.
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_residue: out_valid=%b, required 0", out_valid);
        end
    endtask

    // Send one vector, hold out_ready=1, and compare each code against the model.
    task automatic test_stream(input string name, input logic [N-1:0] v);
        bit ok;
        int exp[$];
        codes_of(v, exp);
        out_ready = 1'b1;
        offer(v, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_accept: in_ready timeout, required in_ready=1", name);
        end
        foreach (exp[i]) begin
            checks++;
            if (out_valid !== 1'b1 || s !== 2'(exp[i]) || last !== (i == exp.size() - 1)) begin
                errors++;
                $display("FAIL %s_code%0d: out_valid=%b s=%0d last=%b, required 1 %0d %0d",
                         name, i, out_valid, s, last, exp[i], (i == exp.size() - 1));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        offer(4'b0110, ok);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (!ok || out_valid !== 1'b1 || s !== 2'd1 || last !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: out_valid=%b s=%0d last=%b, required 1 1 0", c, out_valid, s, last);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || s !== 2'd2 || last !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b s=%0d last=%b, required 1 2 1", out_valid, s, last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_done: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_zero_ignored();
        bit ok;
        out_ready = 1'b1;
        offer(4'b0000, ok);
        checks++;
        if (!ok || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_vector: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        // While BUSY on 0001, an offered 1000 must not be sampled.
        out_ready = 1'b0;
        offer(4'b0001, ok);
        d        = 4'b1000;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || s !== 2'd0 || last !== 1'b1) begin
            errors++;
            $display("FAIL ignored_busy: in_ready=%b out_valid=%b s=%0d last=%b, required 0 1 0 1", in_ready, out_valid, s, last);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_only_one: out_valid=%b s=%0d, required out_valid=0", out_valid, s);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignored_no_extra: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    // Random vectors, random out_ready, and random in_valid/d noise while BUSY.
    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit ok;
            int exp[$];
            int idx    = 0;
            int budget = 0;
            logic [N-1:0] v = N'($urandom_range(0, 2**N - 1));
            codes_of(v, exp);
            out_ready = $urandom_range(0, 1);
            offer(v, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random%0d_accept: in_ready timeout", t);
            end
            while (idx < exp.size() && budget < 200) begin
                checks++;
                if (out_valid !== 1'b1 || s !== 2'(exp[idx]) || last !== (idx == exp.size() - 1)) begin
                    errors++;
                    $display("FAIL random%0d_code%0d v=%b: out_valid=%b s=%0d last=%b, required 1 %0d %0d",
                             t, idx, v, out_valid, s, last, exp[idx], (idx == exp.size() - 1));
                end
                out_ready = $urandom_range(0, 1);
                in_valid  = $urandom_range(0, 1);
                d         = N'($urandom_range(0, 2**N - 1));
                tick();
                in_valid = 1'b0;
                if (out_ready) idx++;
                budget++;
            end
            checks++;
            if (idx != exp.size() || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL random%0d_done v=%b: emitted=%0d of %0d out_valid=%b in_ready=%b, required all, 0, 1",
                         t, v, idx, exp.size(), out_valid, in_ready);
            end
        end
    endtask

`ifdef ENC_ONEHOT_ERR_EN
    task automatic test_err();
        bit ok;
        out_ready = 1'b1;
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_initial_clear: err=%b, required 0", err);
        end
        offer(4'b0011, ok);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b, required 1", err);
        end
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
        offer(4'b1000, ok);
        checks++;
        if (err !== 1'b0 || s !== 2'd3 || last !== 1'b1) begin
            errors++;
            $display("FAIL err_onehot: err=%b s=%0d last=%b, required 0 3 1", err, s, last);
        end
        tick();
        // When set and clear fall on the same edge, set wins.
        err_clr  = 1'b1;
        offer(4'b0101, ok);
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins: err=%b, required 1", err);
        end
        tick();
        tick();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        d         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef ENC_ONEHOT_ERR_EN
        err_clr   = 1'b0;
`endif
        #2;
        checks++;
        if (out_valid !== 1'b0 || last !== 1'b0 || s !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b last=%b s=%0d, required 0 0 0", out_valid, last, s);
        end
        #10 rst_n = 1'b1;
        tick();

        test_reset();
        test_stream("one_hot", 4'b0100);
        test_stream("multi_hot", 4'b1011);
        test_stream("all_ones", 4'b1111);
        test_backpressure();
        test_zero_ignored();
        test_random();
`ifdef ENC_ONEHOT_ERR_EN
        test_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
